// File: rtl/dsp_m_pkg.sv
// Shared constants and helpers for the DSP slice M-register pipeline.
package dsp_m_pkg;
  localparam int DEPTH_MAX = 4;
  localparam int NCH_MAX   = 4;
  localparam int FILL_W    = 3;
  localparam int RV_W      = 128;

  // Reset word: MSB set, so U+V of two reset words wraps to zero.
  function automatic logic [RV_W-1:0] rst_val(input int width);
    return {{(RV_W-1){1'b0}}, 1'b1} << (width - 1);
  endfunction
endpackage

// File: rtl/dsp_m_stage.sv
// One M register stage: U/V for all channels plus the shared valid bit.
module dsp_m_stage
  import dsp_m_pkg::*;
#(
  parameter int             BW   = 90,
  parameter logic [BW-1:0]  RVAL = '0
) (
  input  logic          CLK_mreg,
  input  logic          RSTM,
  input  logic          CE,
  input  logic          SCLR,
  input  logic [BW-1:0] i_u,
  input  logic [BW-1:0] i_v,
  input  logic          i_vld,
  output logic [BW-1:0] o_u,
  output logic [BW-1:0] o_v,
  output logic          o_vld
);
  logic [BW-1:0] r_u, r_v;
  logic          r_vld;

  always_ff @(posedge CLK_mreg or negedge RSTM) begin
    if (!RSTM) begin
      r_u   <= RVAL;
      r_v   <= RVAL;
      r_vld <= 1'b0;
    end else if (SCLR) begin
      r_u   <= RVAL;
      r_v   <= RVAL;
      r_vld <= 1'b0;
    end else if (CE) begin
      r_u   <= i_u;
      r_v   <= i_v;
      r_vld <= i_vld;
    end
  end

  assign o_u   = r_u;
  assign o_v   = r_v;
  assign o_vld = r_vld;
endmodule

// File: rtl/dsp_m_pipe.sv
// Multiplier-output pipeline: NCH channels of U/V through DEPTH stages,
// with valid tracking, occupancy count and optional per-channel U+V.
module dsp_m_pipe
  import dsp_m_pkg::*;
#(
  parameter int WIDTH  = 45,
  parameter int DEPTH  = 1,
  parameter int NCH    = 2,
  parameter int SUM_EN = 0
) (
  input  logic                  CLK_mreg,
  input  logic                  RSTM,
  input  logic                  CEM,
  input  logic                  SCLR,
  input  logic                  ZERO,
  input  logic                  IN_VALID,
  input  logic [NCH*WIDTH-1:0]  U,
  input  logic [NCH*WIDTH-1:0]  V,
  output logic [NCH*WIDTH-1:0]  U_DATA,
  output logic [NCH*WIDTH-1:0]  V_DATA,
  output logic [NCH*WIDTH-1:0]  SUM_DATA,
  output logic                  OUT_VALID,
  output logic [FILL_W-1:0]     FILL
);
  localparam int                BW      = NCH * WIDTH;
  localparam logic [WIDTH-1:0]  RST_VAL = WIDTH'(rst_val(WIDTH));
  localparam logic [BW-1:0]     RST_BUS = {NCH{RST_VAL}};

  if (DEPTH < 0 || DEPTH > DEPTH_MAX || NCH < 1 || NCH > NCH_MAX) begin : g_bad_param
    $error("dsp_m_pipe: DEPTH=%0d NCH=%0d out of range", DEPTH, NCH);
  end

  logic [BW-1:0] w_u0, w_v0;
  assign w_u0 = ZERO ? RST_BUS : U;
  assign w_v0 = ZERO ? RST_BUS : V;

  if (DEPTH == 0) begin : g_bypass
    logic w_unused;
    assign w_unused  = &{1'b0, CLK_mreg, RSTM, CEM, SCLR};
    assign U_DATA    = w_u0;
    assign V_DATA    = w_v0;
    assign OUT_VALID = IN_VALID;
    assign FILL      = '0;
  end else begin : g_pipe
    logic [DEPTH:0][BW-1:0] w_u, w_v;
    logic [DEPTH:0]         w_vld_pipe;
    logic [FILL_W-1:0]      r_fill;

    assign w_u[0]        = w_u0;
    assign w_v[0]        = w_v0;
    assign w_vld_pipe[0] = IN_VALID;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stg
      dsp_m_stage #(.BW(BW), .RVAL(RST_BUS)) u_stg (
        .CLK_mreg (CLK_mreg),
        .RSTM     (RSTM),
        .CE       (CEM),
        .SCLR     (SCLR),
        .i_u      (w_u[i]),
        .i_v      (w_v[i]),
        .i_vld    (w_vld_pipe[i]),
        .o_u      (w_u[i+1]),
        .o_v      (w_v[i+1]),
        .o_vld    (w_vld_pipe[i+1])
      );
    end

    // In/out valids bound the count to 0..DEPTH by construction.
    always_ff @(posedge CLK_mreg or negedge RSTM) begin
      if (!RSTM)      r_fill <= '0;
      else if (SCLR)  r_fill <= '0;
      else if (CEM)   r_fill <= r_fill + FILL_W'(IN_VALID) - FILL_W'(w_vld_pipe[DEPTH]);
    end

    assign U_DATA    = w_u[DEPTH];
    assign V_DATA    = w_v[DEPTH];
    assign OUT_VALID = w_vld_pipe[DEPTH];
    assign FILL      = r_fill;
  end

  for (genvar k = 0; k < NCH; k++) begin : g_sum
    if (SUM_EN != 0) begin : g_add
      assign SUM_DATA[k*WIDTH +: WIDTH] = U_DATA[k*WIDTH +: WIDTH] + V_DATA[k*WIDTH +: WIDTH];
    end else begin : g_zero
      assign SUM_DATA[k*WIDTH +: WIDTH] = '0;
    end
  end
endmodule
